gate_sweep_checker: RTL and testbench

Upstream stimulus and checker stage for the mux-based universal gate block (NAND/NOR outputs).
- On a start pulse, drives all four (a,b) combinations into the gate block in order.
- After a programmable settle time, samples nand_in/nor_in and compares each against the expected values ~(a&b) and ~(a|b).
- Reports per-combination pass/fail, the captured outputs, and an overall verdict.
- Turns the gate block into a self-checking unit for on-chip bring-up.

---
 rtl/gate_sweep_checker.sv | 156 +++++++++++++++
 tb/tb_gate_sweep_checker.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/gate_sweep_checker.sv
// Drives all four (a,b) combinations into the NAND/NOR gate block, samples
// the returned outputs after a settle time, and reports per-combination and overall results.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; results from the last sweep are held
// S_APPLY  | a/b driven for current idx; settle counter loaded
// S_SETTLE | counting down SETTLE_CYCLES while the gate block settles
// S_CHECK  | sample nand_in/nor_in, score, advance idx or finish
// S_DONE   | one-cycle done pulse with final pass verdict valid
module gate_sweep_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       nand_in,
  input  logic       nor_in,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_vec,
  output logic [2:0] err_count,
  output logic [3:0] nand_cap,
  output logic [3:0] nor_cap
);

  generate
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
      $error("gate_sweep_checker: SETTLE_CYCLES must be in 1..15");
    end
    if (SETTLE_CYCLES >= (1 << CNT_W)) begin : g_bad_cnt_w
      $error("gate_sweep_checker: CNT_W too narrow for SETTLE_CYCLES");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_idx;
  logic [1:0]       w_idx_inc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_a;
  logic             r_b;
  logic             r_pass;
  logic [3:0]       r_fail_vec;
  logic [2:0]       r_err_count;
  logic [3:0]       r_nand_cap;
  logic [3:0]       r_nor_cap;
  logic             w_busy;
  logic             w_done;
  logic             w_mismatch;

  assign w_idx_inc  = r_idx + 2'd1;
  // A combination fails once, no matter whether one or both outputs are wrong.
  assign w_mismatch = (nand_in != ~(r_a & r_b)) | (nor_in != ~(r_a | r_b));

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_APPLY;
      end
      S_APPLY: begin
        w_busy      = 1'b1;
        w_state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        w_busy = 1'b1;
        if (r_cnt == CNT_W'(1)) w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        w_busy      = 1'b1;
        w_state_nxt = (r_idx == 2'd3) ? S_DONE : S_APPLY;
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= 2'd0;
      r_cnt       <= '0;
      r_a         <= 1'b0;
      r_b         <= 1'b0;
      r_pass      <= 1'b0;
      r_fail_vec  <= 4'd0;
      r_err_count <= 3'd0;
      r_nand_cap  <= 4'd0;
      r_nor_cap   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_idx       <= 2'd0;
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_vec  <= 4'd0;
            r_err_count <= 3'd0;
            r_nand_cap  <= 4'd0;
            r_nor_cap   <= 4'd0;
          end
        end
        S_APPLY:  r_cnt <= CNT_W'(SETTLE_CYCLES);
        S_SETTLE: r_cnt <= r_cnt - CNT_W'(1);
        S_CHECK: begin
          r_nand_cap[r_idx] <= nand_in;
          r_nor_cap[r_idx]  <= nor_in;
          if (w_mismatch) begin
            r_fail_vec[r_idx] <= 1'b1;
            r_err_count       <= r_err_count + 3'd1;
          end
          if (r_idx == 2'd3) begin
            // Verdict must include this last combination, so it is folded in here.
            r_pass <= (r_fail_vec == 4'd0) && !w_mismatch;
          end else begin
            r_idx <= w_idx_inc;
            r_a   <= w_idx_inc[1];
            r_b   <= w_idx_inc[0];
          end
        end
        default: ;
      endcase
    end
  end

  assign a         = r_a;
  assign b         = r_b;
  assign busy      = w_busy;
  assign done      = w_done;
  assign pass      = r_pass;
  assign fail_vec  = r_fail_vec;
  assign err_count = r_err_count;
  assign nand_cap  = r_nand_cap;
  assign nor_cap   = r_nor_cap;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench for gate_sweep_checker: a behavioural gate block with fault
// modes feeds the main instance; a second instance runs with SETTLE_CYCLES=1.
module tb_gate_sweep_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       nand_in, nor_in;
  logic       a, b, busy, done, pass;
  logic [3:0] fail_vec, nand_cap, nor_cap;
  logic [2:0] err_count;

  logic       start1 = 1'b0;
  logic       nand1, nor1;
  logic       a1, b1, busy1, done1, pass1;
  logic [3:0] fv1, nc1, rc1;
  logic [2:0] ec1;

  // 0 = healthy gate, 1 = nand stuck at 1, 2 = nand/nor swapped
  int fault_mode = 0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always_comb begin
    nand_in = ~(a & b);
    nor_in  = ~(a | b);
    if (fault_mode == 1) nand_in = 1'b1;
    if (fault_mode == 2) begin
      nand_in = ~(a | b);
      nor_in  = ~(a & b);
    end
  end

  assign nand1 = ~(a1 & b1);
  assign nor1  = ~(a1 | b1);

  gate_sweep_checker #(.SETTLE_CYCLES(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .nand_in(nand_in), .nor_in(nor_in),
    .a(a), .b(b), .busy(busy), .done(done), .pass(pass), .fail_vec(fail_vec),
    .err_count(err_count), .nand_cap(nand_cap), .nor_cap(nor_cap)
  );

  gate_sweep_checker #(.SETTLE_CYCLES(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .nand_in(nand1), .nor_in(nor1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1), .fail_vec(fv1),
    .err_count(ec1), .nand_cap(nc1), .nor_cap(rc1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Start pulse sampled at edge E; done expected 16 cycles later for SETTLE_CYCLES=2.
  task automatic sweep(input string tag, input bit repulse,
                       input logic [3:0] e_fail, input logic [2:0] e_err,
                       input logic e_pass, input logic [3:0] e_nand,
                       input logic [3:0] e_nor);
    int k;
    @(negedge clk); start = 1'b1;
    @(posedge clk); k = 0;
    @(negedge clk); start = 1'b0;
    chk({tag, "_busy_at_E"}, busy, 1);
    chk({tag, "_cleared_at_E"}, {pass, fail_vec, err_count, nand_cap, nor_cap}, 0);
    while (!done && k < 60) begin
      start = repulse && (k == 2 || k == 9);
      @(posedge clk); k++;
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, "_latency"}, k, 16);
    chk({tag, "_busy_in_done"}, busy, 0);
    chk({tag, "_fail_vec"}, fail_vec, e_fail);
    chk({tag, "_err_count"}, err_count, e_err);
    chk({tag, "_pass"}, pass, e_pass);
    chk({tag, "_nand_cap"}, nand_cap, e_nand);
    chk({tag, "_nor_cap"}, nor_cap, e_nor);
    @(posedge clk); @(negedge clk);
    chk({tag, "_done_one_cycle"}, {done, busy}, 0);
    chk({tag, "_ab_hold_11"}, {a, b}, 2'b11);
    chk({tag, "_results_held"}, {pass, fail_vec, err_count}, {e_pass, e_fail, e_err});
  endtask

  initial begin
    int k;
    int ndone;
    #12;
    chk("reset_outputs", {a, b, busy, done, pass, fail_vec, err_count, nand_cap, nor_cap}, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {busy, done}, 0);

    fault_mode = 0;
    sweep("good", 1'b0, 4'b0000, 3'd0, 1'b1, 4'b0111, 4'b0001);
    fault_mode = 1;
    sweep("nand_stuck1", 1'b0, 4'b1000, 3'd1, 1'b0, 4'b1111, 4'b0001);
    fault_mode = 2;
    sweep("swapped", 1'b0, 4'b0110, 3'd2, 1'b0, 4'b0001, 4'b0111);
    fault_mode = 0;
    sweep("repulse", 1'b1, 4'b0000, 3'd0, 1'b1, 4'b0111, 4'b0001);

    // Asynchronous reset partway through combination 1, away from any edge.
    fault_mode = 1;
    @(negedge clk); start = 1'b1;
    @(posedge clk); k = 0;
    @(negedge clk); start = 1'b0;
    while (k < 7) begin
      @(posedge clk); k++;
    end
    @(negedge clk);
    chk("pre_reset_ab", {a, b, busy}, 3'b011);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_values", {a, b, busy, done, pass, fail_vec, err_count, nand_cap, nor_cap}, 0);
    @(negedge clk); rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("no_done_after_abort", ndone, 0);
    fault_mode = 0;
    sweep("after_reset", 1'b0, 4'b0000, 3'd0, 1'b1, 4'b0111, 4'b0001);

    // SETTLE_CYCLES=1 instance with start held high: sweeps of 12 cycles with one IDLE gap.
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); k = 0;
    @(negedge clk);
    while (!done1 && k < 60) begin
      @(posedge clk); k++;
      @(negedge clk);
    end
    chk("s1_first_done", k, 12);
    chk("s1_first_results", {pass1, fv1, ec1, nc1, rc1}, {1'b1, 4'b0000, 3'd0, 4'b0111, 4'b0001});
    @(posedge clk); k++; @(negedge clk);
    chk("s1_idle_gap", {busy1, done1, pass1}, 3'b001);
    @(posedge clk); k++; @(negedge clk);
    chk("s1_second_start", {busy1, done1}, 2'b10);
    chk("s1_results_cleared", {pass1, fv1, ec1, nc1, rc1}, 0);
    while (!done1 && k < 80) begin
      @(posedge clk); k++;
      @(negedge clk);
    end
    chk("s1_second_done", k, 26);
    chk("s1_second_pass", {pass1, nc1, rc1}, {1'b1, 4'b0111, 4'b0001});
    start1 = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
